// File: rtl/sram_2p_march_bist_ctrl_if.sv
// Port bundle between the March C- BIST controller and one port of a 2P SRAM macro.
// The master side is the controller; the slave side is the macro/test environment.
interface sram_2p_march_bist_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic              FAIL;
  logic [ADDR_W-1:0] FAIL_ADDR;
  logic [2:0]        FAIL_ELEM;
  logic [CNT_W-1:0]  FAIL_COUNT;
  logic              BIST_EN;
  logic              BIST_MEN;
  logic              BIST_WEN;
  logic              BIST_REN;
  logic [ADDR_W-1:0] BIST_ADDR;
  logic [DATA_W-1:0] BIST_DIN;
  logic [DATA_W-1:0] BIST_BM;
  logic [DATA_W-1:0] DOUT;

  modport master (
    input  START, DOUT,
    output BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_COUNT,
    output BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM
  );

  modport slave (
    output START, DOUT,
    input  BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_COUNT,
    input  BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM
  );
endinterface

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST sequencer for one SRAM port: issues one op per cycle, compares read
// data one cycle after each read, and reports sticky pass/fail with first-fail info.
module sram_2p_march_bist_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input logic                       CLK,
  input logic                       RST,
  sram_2p_march_bist_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] A_MAX  = '1;
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam int                STAGES = 1;

  state_t state_q, state_d;

  // Cursor for the next op to issue; last_q marks that the final op is already out.
  logic [2:0]        elem_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ph_q, last_q;

  logic [2:0]        cur_e, nxt_e;
  logic [ADDR_W-1:0] cur_a, nxt_a;
  logic              cur_p, nxt_p;
  logic              two_op, cur_rd, cur_d1, down, at_end, cur_last;
  logic              start_fire, issue;

  logic              en_q, men_q, wen_q;
  logic [ADDR_W-1:0] baddr_q;
  logic [DATA_W-1:0] din_q, bm_q;
  logic [2:0]        op_elem_q;

  // vld_pipe[0] is the read-enable flop, vld_pipe[STAGES] marks DOUT ready to compare.
  logic [STAGES:0]   vld_pipe;
  logic              cmp_exp1_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [2:0]        cmp_elem_q;
  logic              miscmp;

  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;
  logic [CNT_W-1:0]  fail_cnt_q;

  assign start_fire = bus.START && (state_q == S_IDLE || state_q == S_DONE);
  assign issue      = start_fire || (state_q == S_RUN && !last_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_fire) state_d = S_RUN;
      S_RUN:   if (last_q)     state_d = S_DRAIN;
      S_DRAIN:                 state_d = S_DONE;
      S_DONE:  if (start_fire) state_d = S_RUN;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Decode the op at the cursor and the cursor step after it.
  always_comb begin
    cur_e = elem_q;
    cur_a = addr_q;
    cur_p = ph_q;
    if (start_fire) begin
      cur_e = 3'd0;
      cur_a = '0;
      cur_p = 1'b0;
    end
    two_op   = (cur_e >= 3'd1) && (cur_e <= 3'd4);
    cur_rd   = (cur_e == 3'd5) || (two_op && !cur_p);
    cur_d1   = (cur_e == 3'd1) || (cur_e == 3'd3);
    down     = (cur_e == 3'd3) || (cur_e == 3'd4);
    at_end   = down ? (cur_a == '0) : (cur_a == A_MAX);
    cur_last = (cur_e == 3'd5) && (cur_a == A_MAX);
    nxt_e    = cur_e;
    nxt_a    = cur_a;
    nxt_p    = 1'b0;
    if (two_op && !cur_p) begin
      nxt_p = 1'b1;
    end else if (at_end) begin
      nxt_e = cur_e + 3'd1;
      nxt_a = (nxt_e == 3'd3 || nxt_e == 3'd4) ? A_MAX : '0;
    end else begin
      nxt_a = down ? cur_a - A_ONE : cur_a + A_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      elem_q    <= '0;
      addr_q    <= '0;
      ph_q      <= 1'b0;
      last_q    <= 1'b0;
      en_q      <= 1'b0;
      men_q     <= 1'b0;
      wen_q     <= 1'b0;
      vld_pipe  <= '0;
      baddr_q   <= '0;
      din_q     <= '0;
      bm_q      <= '0;
      op_elem_q <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (issue) begin
        en_q        <= 1'b1;
        men_q       <= 1'b1;
        wen_q       <= !cur_rd;
        vld_pipe[0] <= cur_rd;
        baddr_q     <= cur_a;
        din_q       <= (!cur_rd && cur_d1) ? '1 : '0;
        bm_q        <= cur_rd ? '0 : '1;
        op_elem_q   <= cur_e;
        elem_q      <= nxt_e;
        addr_q      <= nxt_a;
        ph_q        <= nxt_p;
        last_q      <= cur_last;
      end else begin
        en_q        <= 1'b0;
        men_q       <= 1'b0;
        wen_q       <= 1'b0;
        vld_pipe[0] <= 1'b0;
        baddr_q     <= '0;
        din_q       <= '0;
        bm_q        <= '0;
      end
    end
  end

  // Expected data, address and element follow the read by one cycle, in step with DOUT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmp_exp1_q <= 1'b0;
      cmp_addr_q <= '0;
      cmp_elem_q <= '0;
    end else begin
      cmp_exp1_q <= (op_elem_q == 3'd2) || (op_elem_q == 3'd4);
      cmp_addr_q <= baddr_q;
      cmp_elem_q <= op_elem_q;
    end
  end

  assign miscmp = vld_pipe[STAGES] &&
                  (bus.DOUT != (cmp_exp1_q ? {DATA_W{1'b1}} : {DATA_W{1'b0}}));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else if (start_fire) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else if (miscmp) begin
      fail_q <= 1'b1;
      if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
      if (!fail_q) begin
        fail_addr_q <= cmp_addr_q;
        fail_elem_q <= cmp_elem_q;
      end
    end
  end

  assign bus.BUSY       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.DONE       = (state_q == S_DONE);
  assign bus.FAIL       = fail_q;
  assign bus.FAIL_ADDR  = fail_addr_q;
  assign bus.FAIL_ELEM  = fail_elem_q;
  assign bus.FAIL_COUNT = fail_cnt_q;
  assign bus.BIST_EN    = en_q;
  assign bus.BIST_MEN   = men_q;
  assign bus.BIST_WEN   = wen_q;
  assign bus.BIST_REN   = vld_pipe[0];
  assign bus.BIST_ADDR  = baddr_q;
  assign bus.BIST_DIN   = din_q;
  assign bus.BIST_BM    = bm_q;
endmodule

// File: tb/tb_sram_2p_march_bist_ctrl.sv
// Directed bench for the March C- BIST controller: a behavioural macro model per DUT,
// with selectable stuck-at and garbage-read faults, and per-scenario checking tasks.
module tb_sram_2p_march_bist_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  sram_2p_march_bist_ctrl_if #(.DATA_W(32), .ADDR_W(8), .CNT_W(8)) bif ();
  sram_2p_march_bist_ctrl #(.DATA_W(32), .ADDR_W(8), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .bus(bif.master));

  sram_2p_march_bist_ctrl_if #(.DATA_W(8), .ADDR_W(1), .CNT_W(4)) bif2 ();
  sram_2p_march_bist_ctrl #(.DATA_W(8), .ADDR_W(1), .CNT_W(4)) dut2 (
    .CLK(clk), .RST(rst), .bus(bif2.master));

  // 0 = good macro, 1 = bit 5 of word 0x3C stuck at 0, 2 = every read returns garbage
  int          mode = 0;
  logic [31:0] mem [0:255];
  logic [31:0] rdata = '0;
  logic [31:0] wd;
  always @(posedge clk) begin
    if (bif.BIST_EN && bif.BIST_MEN && bif.BIST_WEN) begin
      wd = (mem[bif.BIST_ADDR] & ~bif.BIST_BM) | (bif.BIST_DIN & bif.BIST_BM);
      if (mode == 1 && bif.BIST_ADDR == 8'h3C) wd[5] = 1'b0;
      mem[bif.BIST_ADDR] <= wd;
    end
    if (bif.BIST_EN && bif.BIST_MEN && bif.BIST_REN) rdata <= mem[bif.BIST_ADDR];
  end
  assign bif.DOUT = (mode == 2) ? 32'hA5A5_5A5A : rdata;

  logic [7:0] mem2 [0:1];
  logic [7:0] rdata2 = '0;
  always @(posedge clk) begin
    if (bif2.BIST_EN && bif2.BIST_MEN && bif2.BIST_WEN) mem2[bif2.BIST_ADDR] <= bif2.BIST_DIN;
    if (bif2.BIST_EN && bif2.BIST_MEN && bif2.BIST_REN) rdata2 <= mem2[bif2.BIST_ADDR];
  end
  assign bif2.DOUT = rdata2;

  // Per-op log {we, data bit, addr} and first-cycle snapshot of the last run
  logic [9:0]  op_log [0:2599];
  int          r_busy, r_ops, r_viol;
  bit          r_to, r_rst;
  logic        f_busy, f_done, f_fail;
  logic [7:0]  f_cnt, f_faddr;
  logic [2:0]  f_felem;

  task automatic run_main(input int start_at, input int rst_at);
    bit done = 0;
    int idx;
    r_busy = 0; r_ops = 0; r_viol = 0; r_to = 0; r_rst = 0;
    @(negedge clk); bif.START = 1'b1;
    @(negedge clk); bif.START = 1'b0;
    f_busy = bif.BUSY; f_done = bif.DONE; f_fail = bif.FAIL;
    f_cnt = bif.FAIL_COUNT; f_faddr = bif.FAIL_ADDR; f_felem = bif.FAIL_ELEM;
    for (int c = 0; c < 3000 && !done && !r_rst; c++) begin
      if (c > 0) begin
        @(negedge clk);
        bif.START = 1'b0;
      end
      if (bif.BUSY) r_busy++;
      if (bif.BIST_MEN) begin
        idx = r_ops;
        if (idx < 2600) op_log[idx] = {bif.BIST_WEN, bif.BIST_DIN[0], bif.BIST_ADDR};
        if (bif.BIST_WEN == bif.BIST_REN || !bif.BIST_EN) r_viol++;
        if (bif.BIST_WEN && bif.BIST_BM != 32'hFFFF_FFFF) r_viol++;
        if (bif.BIST_DIN != 32'h0 && bif.BIST_DIN != 32'hFFFF_FFFF) r_viol++;
        r_ops++;
        if (idx == start_at) bif.START = 1'b1;
        if (idx == rst_at) begin
          rst = 1'b1;
          r_rst = 1;
        end
      end
      if (bif.DONE) done = 1;
    end
    bif.START = 1'b0;
    if (!done && !r_rst) r_to = 1;
  endtask

  task automatic check_run(input string nm, input bit exp_fail, input logic [7:0] exp_cnt,
                           input logic [7:0] exp_addr, input logic [2:0] exp_elem);
    n_cmp++; if (r_to !== 1'b0) begin n_bad++; $display("FAIL %s timeout: no DONE", nm); end
    n_cmp++; if (r_busy !== 2561) begin n_bad++; $display("FAIL %s busy_cycles got %0d want 2561", nm, r_busy); end
    n_cmp++; if (r_ops !== 2560) begin n_bad++; $display("FAIL %s op_count got %0d want 2560", nm, r_ops); end
    n_cmp++; if (r_viol !== 0) begin n_bad++; $display("FAIL %s op_shape_violations got %0d want 0", nm, r_viol); end
    n_cmp++;
    if ({bif.DONE, bif.BUSY, bif.FAIL} !== {1'b1, 1'b0, exp_fail}) begin
      n_bad++; $display("FAIL %s done/busy/fail got %b%b%b want 10%b", nm, bif.DONE, bif.BUSY, bif.FAIL, exp_fail);
    end
    n_cmp++;
    if ({bif.FAIL_COUNT, bif.FAIL_ADDR, bif.FAIL_ELEM} !== {exp_cnt, exp_addr, exp_elem}) begin
      n_bad++; $display("FAIL %s cnt/addr/elem got %h/%h/%0d want %h/%h/%0d", nm,
                        bif.FAIL_COUNT, bif.FAIL_ADDR, bif.FAIL_ELEM, exp_cnt, exp_addr, exp_elem);
    end
    n_cmp++;
    if ({bif.BIST_EN, bif.BIST_MEN, bif.BIST_WEN, bif.BIST_REN, bif.BIST_ADDR, bif.BIST_DIN, bif.BIST_BM} !== '0) begin
      n_bad++; $display("FAIL %s bist_idle_in_done got en%b men%b wen%b ren%b want all 0", nm,
                        bif.BIST_EN, bif.BIST_MEN, bif.BIST_WEN, bif.BIST_REN);
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_cmp++;
    if ({bif.BUSY, bif.DONE, bif.FAIL, bif.FAIL_COUNT, bif.FAIL_ADDR, bif.FAIL_ELEM,
         bif.BIST_EN, bif.BIST_MEN, bif.BIST_WEN, bif.BIST_REN, bif.BIST_ADDR,
         bif.BIST_DIN, bif.BIST_BM} !== '0) begin
      n_bad++; $display("FAIL %s outputs not zero: busy%b done%b fail%b cnt%h men%b want all 0", nm,
                        bif.BUSY, bif.DONE, bif.FAIL, bif.FAIL_COUNT, bif.BIST_MEN);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_cmp++;
    if ({bif2.BUSY, bif2.DONE, bif2.BIST_MEN} !== 3'b000) begin
      n_bad++; $display("FAIL reset_small got %b%b%b want 000", bif2.BUSY, bif2.DONE, bif2.BIST_MEN);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_and_sequence();
    int         ix [9] = '{0, 1, 255, 256, 257, 768, 1280, 1281, 2559};
    logic [9:0] ex [9] = '{{2'b10, 8'h00}, {2'b10, 8'h01}, {2'b10, 8'hFF},
                           {2'b00, 8'h00}, {2'b11, 8'h00}, {2'b00, 8'h00},
                           {2'b00, 8'hFF}, {2'b11, 8'hFF}, {2'b00, 8'hFF}};
    mode = 0;
    run_main(-1, -1);
    check_run("good", 1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (op_log[ix[i]] !== ex[i]) begin
        n_bad++; $display("FAIL seq op%0d {we,d,addr} got %b want %b", ix[i], op_log[ix[i]], ex[i]);
      end
    end
  endtask

  task automatic test_stuck_and_restart();
    mode = 1;
    run_main(500, -1);  // the START pulse mid-run must be ignored
    check_run("stuck", 1'b1, 8'd2, 8'h3C, 3'd2);
    run_main(-1, -1);
    n_cmp++;
    if ({f_busy, f_done, f_fail, f_cnt, f_faddr, f_felem} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
      n_bad++; $display("FAIL restart_clear got busy%b done%b fail%b cnt%h addr%h elem%0d want 1 0 0 00 00 0",
                        f_busy, f_done, f_fail, f_cnt, f_faddr, f_felem);
    end
    check_run("stuck_rerun", 1'b1, 8'd2, 8'h3C, 3'd2);
  endtask

  task automatic test_saturate();
    mode = 2;
    run_main(-1, -1);
    check_run("garbage", 1'b1, 8'hFF, 8'h00, 3'd1);
  endtask

  task automatic test_reset_mid_run();
    mode = 0;
    run_main(-1, 1000);
    n_cmp++;
    if (r_rst !== 1'b1) begin n_bad++; $display("FAIL rst_mid never reached op 1000 (ops %0d)", r_ops); end
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    run_main(-1, -1);
    check_run("after_rst", 1'b0, 8'h00, 8'h00, 3'd0);
  endtask

  task automatic test_degenerate();
    // {we, addr, data} for N=2
    logic [2:0] ex [20] = '{3'd4, 3'd6, 3'd0, 3'd5, 3'd2, 3'd7, 3'd0, 3'd4, 3'd2, 3'd6,
                            3'd2, 3'd7, 3'd0, 3'd5, 3'd2, 3'd6, 3'd0, 3'd4, 3'd0, 3'd2};
    logic [2:0] got [20];
    int  ops = 0, busy = 0;
    bit  done = 0;
    @(negedge clk); bif2.START = 1'b1;
    @(negedge clk); bif2.START = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (bif2.BUSY) busy++;
      if (bif2.BIST_MEN) begin
        if (ops < 20) got[ops] = {bif2.BIST_WEN, bif2.BIST_ADDR, bif2.BIST_DIN[0]};
        ops++;
      end
      if (bif2.DONE) done = 1;
    end
    n_cmp++;
    if ({done, ops, busy} !== {1'b1, 32'd20, 32'd21}) begin
      n_bad++; $display("FAIL n2_run done%b ops %0d busy %0d want 1 20 21", done, ops, busy);
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (i < ops && got[i] !== ex[i]) begin
        n_bad++; $display("FAIL n2_op%0d {we,a,d} got %b want %b", i, got[i], ex[i]);
      end else if (i >= ops) begin
        n_bad++; $display("FAIL n2_op%0d missing want %b", i, ex[i]);
      end
    end
    n_cmp++;
    if ({bif2.FAIL, bif2.FAIL_COUNT} !== 5'b0) begin
      n_bad++; $display("FAIL n2_result fail%b cnt%h want 0 0", bif2.FAIL, bif2.FAIL_COUNT);
    end
  endtask

  initial begin
    bif.START  = 1'b0;
    bif2.START = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem2[0] = '0;
    mem2[1] = '0;
    test_reset();
    test_good_and_sequence();
    test_stuck_and_restart();
    test_saturate();
    test_reset_mid_run();
    test_degenerate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
